// File: rtl/scroll_scheduler.sv
// Scroll sequencer for the layer stack: 1 ms tick divider, LFSR-fed next-layer data,
// and scroll-window timing. Define SCROLL_QUEUE_EN to queue up to 3 requests made while busy.
module scroll_scheduler #(
  parameter int          TICKS_PER_MS  = 65000,
  parameter int          SCROLL_MS     = 150,
  parameter int          SETTLE_CYCLES = 2,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1,
  parameter logic [6:0]  INIT_MAP      = 7'b0001000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pause,
  input  logic       scroll_req,
  output logic       one_ms_tick,
  output logic       layer_start,
  output logic [0:6] new_layer_map,
  output logic [0:6] new_block_type,
  output logic       busy,
  output logic       scroll_done,
  output logic [1:0] pending_cnt
);

  localparam int             DIV_W       = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(TICKS_PER_MS - 1);
  localparam logic [7:0]     SCROLL_LAST = 8'(SCROLL_MS - 1);
  localparam logic [7:0]     SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic [15:0]    LFSR_MASK   = 16'hB400;
  localparam logic [6:0]     EMPTY_FIX   = 7'b0001000;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_SCROLL = 3'd2,
    S_SETTLE = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t           fsm_state;
  state_t           state_next;
  logic [DIV_W-1:0] div_cnt;
  logic [15:0]      lfsr;
  logic [7:0]       tick_cnt;
  logic [7:0]       settle_cnt;

  // Divider holds while paused, so a pause stretches the scroll window cycle for cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (!pause) begin
      div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
    end
  end

  assign one_ms_tick = !pause && (div_cnt == DIV_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr <= LFSR_SEED;
    end else begin
      lfsr <= lfsr[0] ? ((lfsr >> 1) ^ LFSR_MASK) : (lfsr >> 1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_state <= S_IDLE;
    end else begin
      fsm_state <= state_next;
    end
  end

  // scroll_req is a single-cycle strobe with no ready: it is taken in S_IDLE, queued while
  // busy when the queue is built in, and otherwise dropped.
  always_comb begin
    state_next = fsm_state;
    case (fsm_state)
      S_IDLE:   if (scroll_req || (pending_cnt != 2'd0)) state_next = S_START;
      S_START:  state_next = S_SCROLL;
      S_SCROLL: begin
        if (one_ms_tick && (tick_cnt == SCROLL_LAST)) begin
          state_next = (SETTLE_CYCLES == 0) ? S_DONE : S_SETTLE;
        end
      end
      S_SETTLE: if (settle_cnt == SETTLE_LAST) state_next = S_DONE;
      S_DONE:   state_next = (pending_cnt != 2'd0) ? S_START : S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  assign layer_start = (fsm_state == S_START);
  assign scroll_done = (fsm_state == S_DONE);
  assign busy        = (fsm_state != S_IDLE);

  // A tick coinciding with S_START is not counted: the layers only begin moving next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt <= 8'd0;
    end else if (fsm_state == S_START) begin
      tick_cnt <= 8'd0;
    end else if ((fsm_state == S_SCROLL) && one_ms_tick) begin
      tick_cnt <= tick_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      settle_cnt <= 8'd0;
    end else if (fsm_state == S_SETTLE) begin
      settle_cnt <= settle_cnt + 8'd1;
    end else begin
      settle_cnt <= 8'd0;
    end
  end

  // Latched only in S_START so the layers see a value that holds for the whole window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      new_layer_map  <= INIT_MAP;
      new_block_type <= 7'd0;
    end else if (fsm_state == S_START) begin
      new_layer_map  <= (lfsr[6:0] == 7'd0) ? EMPTY_FIX : lfsr[6:0];
      new_block_type <= lfsr[13:7];
    end
  end

`ifdef SCROLL_QUEUE_EN
  logic enq;
  logic deq;

  // While a queued request is waiting in S_IDLE a new one stacks behind it rather than merging.
  assign enq = scroll_req && (busy || (pending_cnt != 2'd0));
  assign deq = (pending_cnt != 2'd0) && ((fsm_state == S_DONE) || (fsm_state == S_IDLE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_cnt <= 2'd0;
    end else begin
      case ({enq, deq})
        2'b10:   if (pending_cnt != 2'd3) pending_cnt <= pending_cnt + 2'd1;
        2'b01:   pending_cnt <= pending_cnt - 2'd1;
        default: pending_cnt <= pending_cnt;
      endcase
    end
  end
`else
  assign pending_cnt = 2'd0;
`endif

endmodule

// File: tb/tb_scroll_scheduler.sv
// Self-checking bench for scroll_scheduler: reference tick/LFSR model plus start/done/map queues.
module tb_scroll_scheduler;
  localparam int          TPM    = 4;
  localparam int          SMS    = 150;
  localparam int          SETTLE = 2;
  localparam logic [15:0] SEED   = 16'hACE1;
  localparam logic [6:0]  IMAP   = 7'b0001000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pause = 1'b0;
  logic       scroll_req = 1'b0;
  logic       one_ms_tick, layer_start, busy, scroll_done;
  logic [0:6] new_layer_map, new_block_type;
  logic [1:0] pending_cnt;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int n_starts = 0;
  int n_dones = 0;
  int last_done_cyc = 0;

  logic [31:0] start_q[$];
  logic [31:0] done_q[$];
  logic [13:0] exp_q[$];

  logic [15:0] m_lfsr;
  int          m_div;
  logic        m_active = 1'b0;
  int          m_ticks = 0;
  int          m_pend = 0;
  logic        map_due = 1'b0;
  logic [13:0] last_map = '0;

  scroll_scheduler #(
    .TICKS_PER_MS(TPM), .SCROLL_MS(SMS), .SETTLE_CYCLES(SETTLE),
    .LFSR_SEED(SEED), .INIT_MAP(IMAP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pause(pause), .scroll_req(scroll_req),
    .one_ms_tick(one_ms_tick), .layer_start(layer_start),
    .new_layer_map(new_layer_map), .new_block_type(new_block_type),
    .busy(busy), .scroll_done(scroll_done), .pending_cnt(pending_cnt)
  );

  // clock / reset-aware reference state
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    logic [15:0] n;
    n = {1'b0, s[15:1]};
    if (s[0]) n = n ^ 16'hB400;
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_lfsr <= SEED;
      m_div  <= 0;
    end else begin
      m_lfsr <= lfsr_step(m_lfsr);
      if (!pause) m_div <= (m_div == TPM - 1) ? 0 : m_div + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // scoreboard / monitor, sampled on the falling edge
  always @(negedge clk) begin
    logic       cur_busy;
    logic [6:0] em;
    if (!rst_n) begin
      start_q.delete();
      done_q.delete();
      exp_q.delete();
      m_active = 1'b0;
      m_ticks  = 0;
      m_pend   = 0;
      map_due  = 1'b0;
    end else begin
      chk("tick", one_ms_tick, (m_div == TPM - 1) && !pause);
      chk("pending", pending_cnt, m_pend);
      chk("busy", busy, m_active || layer_start);
      if (map_due) begin
        map_due = 1'b0;
        if (exp_q.size() != 0) chk("map", {new_block_type, new_layer_map}, exp_q.pop_front());
      end
      if (layer_start) begin
        n_starts++;
        if (start_q.size() == 0) chk("start_unexp", 1, 0);
        else chk("start_cyc", cyc, start_q.pop_front());
        m_active = 1'b1;
        m_ticks  = 0;
        map_due  = 1'b1;
        em = (m_lfsr[6:0] == 7'd0) ? 7'b0001000 : m_lfsr[6:0];
        last_map = {m_lfsr[13:7], em};
        exp_q.push_back(last_map);
      end else if (m_active && one_ms_tick) begin
        m_ticks++;
        if (m_ticks == SMS) done_q.push_back(cyc + SETTLE + 1);
      end
      cur_busy = m_active;
`ifdef SCROLL_QUEUE_EN
      begin
        logic enq, deq;
        enq = scroll_req && (cur_busy || m_pend != 0);
        deq = (m_pend != 0) && (scroll_done || !cur_busy);
        if (deq) start_q.push_back(cyc + 1);
        if (scroll_req && !cur_busy && m_pend == 0) start_q.push_back(cyc + 1);
        if (enq && !deq && m_pend < 3) m_pend++;
        if (deq && !enq) m_pend--;
      end
`else
      if (scroll_req && !cur_busy) start_q.push_back(cyc + 1);
`endif
      if (scroll_done) begin
        n_dones++;
        last_done_cyc = cyc;
        if (done_q.size() == 0) chk("done_unexp", 1, 0);
        else chk("done_cyc", cyc, done_q.pop_front());
        chk("done_ticks", m_ticks, SMS);
        chk("done_map", {new_block_type, new_layer_map}, last_map);
        m_active = 1'b0;
      end
    end
  end

  // driver tasks
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_req();
    scroll_req = 1'b1;
    step(1);
    scroll_req = 1'b0;
  endtask

  task automatic wait_phase();
    for (int k = 0; k < 2 * TPM; k++) begin
      if (m_div == TPM - 1 && !pause) break;
      step(1);
    end
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    while (busy && k < budget) begin
      step(1);
      k++;
    end
    chk("idle_timeout", busy, 0);
  endtask

  initial begin
    int req_cyc, n0, s0;
    logic [15:0] nx;
    logic found;

    // reset state
    step(3);
    chk("rst_map", new_layer_map, IMAP);
    chk("rst_type", new_block_type, 0);
    chk("rst_busy", busy, 0);
    chk("rst_start", layer_start, 0);
    chk("rst_done", scroll_done, 0);
    chk("rst_tick", one_ms_tick, 0);
    chk("rst_pend", pending_cnt, 0);
    rst_n = 1'b1;
    step(7);

    // basic scroll started on divider phase 0
    wait_phase();
    req_cyc = cyc;
    do_req();
    chk("start_pulse", layer_start, 1);
    wait_idle(2000);
    chk("lat_basic", last_done_cyc - req_cyc, 603);
    step(5);

    // pause for 20 cycles mid-scroll
    wait_phase();
    req_cyc = cyc;
    do_req();
    step(100);
    pause = 1'b1;
    step(20);
    pause = 1'b0;
    wait_idle(2000);
    chk("lat_pause", last_done_cyc - req_cyc, 623);
    step(3);

    // empty LFSR map at S_START
    found = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      nx = lfsr_step(m_lfsr);
      if (nx[6:0] == 7'd0) begin
        found = 1'b1;
        break;
      end
      step(1);
    end
    chk("zmap_found", found, 1);
    do_req();
    step(1);
    chk("zmap", new_layer_map, 7'b0001000);
    wait_idle(2000);
    step(3);

    // requests made while busy
    n0 = n_dones;
    s0 = n_starts;
    do_req();
`ifdef SCROLL_QUEUE_EN
    for (int k = 0; k < 5; k++) begin
      step($urandom_range(2, 12));
      do_req();
    end
    step(1);
    chk("q_pend_sat", pending_cnt, 3);
    wait_idle(4000);
    chk("q_scrolls", n_dones - n0, 4);
    chk("q_starts", n_starts - s0, 4);
`else
    step($urandom_range(5, 200));
    do_req();
    step(1);
    chk("nq_pend", pending_cnt, 0);
    wait_idle(2000);
    step(30);
    chk("nq_scrolls", n_dones - n0, 1);
    chk("nq_starts", n_starts - s0, 1);
`endif
    step(3);

    // asynchronous reset mid-scroll
    do_req();
    step($urandom_range(20, 300));
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_start", layer_start, 0);
    chk("arst_map", new_layer_map, IMAP);
    chk("arst_type", new_block_type, 0);
    chk("arst_pend", pending_cnt, 0);
    n0 = n_dones;
    step(2);
    rst_n = 1'b1;
    step(700);
    chk("arst_no_done", n_dones - n0, 0);

    chk("startq_empty", start_q.size(), 0);
    chk("doneq_empty", done_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=%0d exp=0", cyc);
    $fatal(1, "timeout");
  end
endmodule
